// File: rtl/dom_gf_pkg.sv
// Shared GF(2^N) helpers for the DOM masked multiplier: field multiply,
// share-pair enumeration and randomness-width formula.
package dom_gf_pkg;

   localparam int MAX_N      = 8;
   localparam int MAX_SHARES = 5;

   function automatic int z_width(input int n, input int shares);
      return n * shares * (shares - 1) / 2;
   endfunction

   // Pairs (i,j), i<j, enumerated row by row: (0,1),(0,2)..(0,S-1),(1,2)...
   function automatic int pair_index(input int i, input int j, input int shares);
      int lo;
      int hi;
      int p;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      p  = 0;
      for (int k = 0; k < MAX_SHARES; k++) begin
         if (k < lo) p += shares - 1 - k;
      end
      return p + hi - lo - 1;
   endfunction

   // Polynomial-basis multiply; the x^n bit of poly is implied by the shifted-out MSB.
   function automatic logic [MAX_N-1:0] gf_mul(input logic [MAX_N-1:0] a,
                                               input logic [MAX_N-1:0] b,
                                               input int n,
                                               input int poly);
      logic [MAX_N-1:0] ones;
      logic [MAX_N-1:0] mask;
      logic [MAX_N-1:0] top;
      logic [MAX_N-1:0] red;
      logic [MAX_N-1:0] acc;
      logic [MAX_N-1:0] sh;
      logic [MAX_N-1:0] bb;
      ones = '1;
      mask = ~(ones << n);
      top  = mask ^ (mask >> 1);
      red  = MAX_N'(poly) & mask;
      acc  = '0;
      sh   = a & mask;
      bb   = b;
      for (int k = 0; k < MAX_N; k++) begin
         if (k < n) begin
            if (bb[0]) acc ^= sh;
            bb = bb >> 1;
            if ((sh & top) != '0) sh = ((sh << 1) & mask) ^ red;
            else                  sh = (sh << 1) & mask;
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/dom_gf2n_term_reg.sv
// One registered GF(2^N) product term, optionally blinded with a fresh Z,
// with load enable and synchronous active-high reset.
module dom_gf2n_term_reg
   import dom_gf_pkg::*;
#(
   parameter int N     = 2,
   parameter int POLY  = 7,
   parameter bit USE_Z = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] z,
   output logic [N-1:0] q
);

   logic [N-1:0] prod;

   always_comb begin
      prod = N'(gf_mul(MAX_N'(a), MAX_N'(b), N, POLY)) ^ (USE_Z ? z : '0);
   end

   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= prod;
   end

endmodule

// File: rtl/dom_shared_mul_gf2n.sv
// d-th order DOM-indep masked GF(2^N) multiplier with valid tracking and stall.
// Optional macro DOM_UNMASKED_CHECK_EN adds UnmaskedQxDO and a reference-product assertion.
module dom_shared_mul_gf2n
   import dom_gf_pkg::*;
#(
   parameter int N       = 2,
   parameter int POLY    = 7,
   parameter int SHARES  = 2,
   parameter int OUT_REG = 0,
   localparam int ZW     = z_width(N, SHARES)
) (
   input  logic                ClkxCI,
   input  logic                RstxRI,
   input  logic                EnxSI,
   input  logic                InValidxSI,
   input  logic [N*SHARES-1:0] _XxDI,
   input  logic [N*SHARES-1:0] _YxDI,
   input  logic [ZW-1:0]       _ZxDI,
   output logic                OutValidxSO,
   output logic [N*SHARES-1:0] _QxDO
`ifdef DOM_UNMASKED_CHECK_EN
   ,
   output logic [N-1:0]        UnmaskedQxDO
`endif
);

   localparam int LAT = 1 + ((OUT_REG != 0) ? 1 : 0);

   if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("dom_shared_mul_gf2n: N must be in 2..8");
   end
   if (((POLY >> N) & 1) == 0) begin : g_bad_poly
      $error("dom_shared_mul_gf2n: POLY must contain the x^N term");
   end
   if (SHARES < 2 || SHARES > MAX_SHARES) begin : g_bad_shares
      $error("dom_shared_mul_gf2n: SHARES must be in 2..5");
   end

   logic [N-1:0]        term_q [SHARES][SHARES];
   logic [N*SHARES-1:0] q_comp;
   logic [LAT-1:0]      vld_pipe;

   // Every term, cross terms especially, is registered so the compression
   // below never sees glitching, unblinded partial products.
   for (genvar i = 0; i < SHARES; i++) begin : g_row
      for (genvar j = 0; j < SHARES; j++) begin : g_col
         if (i == j) begin : g_inner
            dom_gf2n_term_reg #(.N(N), .POLY(POLY), .USE_Z(1'b0)) u_term (
               .clk (ClkxCI),
               .rst (RstxRI),
               .en  (EnxSI),
               .a   (_XxDI[i*N +: N]),
               .b   (_YxDI[j*N +: N]),
               .z   ('0),
               .q   (term_q[i][j])
            );
         end else begin : g_cross
            localparam int P = pair_index(i, j, SHARES);
            dom_gf2n_term_reg #(.N(N), .POLY(POLY), .USE_Z(1'b1)) u_term (
               .clk (ClkxCI),
               .rst (RstxRI),
               .en  (EnxSI),
               .a   (_XxDI[i*N +: N]),
               .b   (_YxDI[j*N +: N]),
               .z   (_ZxDI[P*N +: N]),
               .q   (term_q[i][j])
            );
         end
      end
   end

   always_comb begin
      q_comp = '0;
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            q_comp[i*N +: N] ^= term_q[i][j];
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [N*SHARES-1:0] q_reg;
      always_ff @(posedge ClkxCI) begin
         if (RstxRI)     q_reg <= '0;
         else if (EnxSI) q_reg <= q_comp;
      end
      assign _QxDO = q_reg;
   end else begin : g_out_comb
      assign _QxDO = q_comp;
   end

   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         vld_pipe <= '0;
      end else if (EnxSI) begin
         vld_pipe[0] <= InValidxSI;
         for (int k = 1; k < LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   assign OutValidxSO = vld_pipe[LAT-1];

`ifdef DOM_UNMASKED_CHECK_EN
   logic [N-1:0] x_plain;
   logic [N-1:0] y_plain;
   logic [N-1:0] q_plain;
   logic [N-1:0] x_dly [LAT];
   logic [N-1:0] y_dly [LAT];

   always_comb begin
      x_plain = '0;
      y_plain = '0;
      q_plain = '0;
      for (int i = 0; i < SHARES; i++) begin
         x_plain ^= _XxDI[i*N +: N];
         y_plain ^= _YxDI[i*N +: N];
         q_plain ^= _QxDO[i*N +: N];
      end
   end

   assign UnmaskedQxDO = q_plain;

   // Unmasked operands travel alongside the data so the reference lines up with Q.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         for (int k = 0; k < LAT; k++) begin
            x_dly[k] <= '0;
            y_dly[k] <= '0;
         end
      end else if (EnxSI) begin
         x_dly[0] <= x_plain;
         y_dly[0] <= y_plain;
         for (int k = 1; k < LAT; k++) begin
            x_dly[k] <= x_dly[k-1];
            y_dly[k] <= y_dly[k-1];
         end
      end
   end

   always @(posedge ClkxCI) begin
      if (!RstxRI && OutValidxSO) begin
         assert (q_plain == N'(gf_mul(MAX_N'(x_dly[LAT-1]), MAX_N'(y_dly[LAT-1]), N, POLY)))
            else $error("dom_shared_mul_gf2n: unmasked product differs from reference");
      end
   end
`endif

endmodule

// File: doc/dom_shared_mul_gf2n.md
Name: dom_shared_mul_gf2n

Overview:
- Parametrised d-th order DOM-indep masked multiplier over GF(2^N), generalising the fixed GF(2^2) shared multiplier to arbitrary field width, field polynomial, share count and pipeline depth.
- Adds valid tracking, a global stall enable and an optional output register.
- Sits inside masked S-box datapaths (GF(2^4)/GF(2^2) tower inversions) and is driven by the shared-data pipeline and the PRNG randomness bus.

Parameters:
- N, 2, field width in bits (2..8).
- POLY, 7, irreducible polynomial including the x^N term, e.g. 7 for N=2, 0x13 for N=4.
- SHARES, 2, number of shares (2..5); protection order is SHARES-1.
- OUT_REG, 0, 1 adds a register after share compression.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  reset, synchronous, active-high.
- EnxSI  in  1  pipeline enable; 0 freezes every register.
- InValidxSI  in  1  input shares valid.
- _XxDI  in  N*SHARES  X shares; share i at bits [i*N +: N].
- _YxDI  in  N*SHARES  Y shares, same packing.
- _ZxDI  in  N*SHARES*(SHARES-1)/2  fresh randomness; pair p at [p*N +: N].
- OutValidxSO  out  1  output shares valid.
- _QxDO  out  N*SHARES  product shares, same packing.

Behaviour:
- Field multiply: polynomial basis, reduced modulo POLY. Implemented as a combinational function; no clock dependency.
- Pair index p enumerates (i,j) with i<j in the order (0,1),(0,2)..(0,S-1),(1,2)... Both cross terms of a pair use the same Z_p:
  - C_ij = X_i*Y_j ^ Z_p
  - C_ji = X_j*Y_i ^ Z_p
- Stage 1 registers, loaded when EnxSI=1:
  - every cross term C_ij (i!=j), SHARES*(SHARES-1) registers of N bits;
  - every inner term I_i = X_i*Y_i, SHARES registers of N bits.
  - Cross terms are always registered, never collapsed combinationally (glitch barrier mandatory).
- Compression: Q_i = I_i ^ XOR over j!=i of C_ij, combinational from stage 1.
- OUT_REG=1: Q_i is registered again under EnxSI.
- Latency LAT = 1 + OUT_REG cycles, counted from the input edge to valid _QxDO.
- Valid pipeline: LAT-deep shift register of InValidxSI, advanced only when EnxSI=1. OutValidxSO is its last stage.
- Data registers load regardless of InValidxSI, so invalid data may propagate. Consumers qualify outputs with OutValidxSO.
- Stall: EnxSI=0 holds all data and valid registers; outputs stay stable for any number of cycles. New inputs presented during a stall are ignored.
- Reset:
  - RstxRI=1 at a clock edge clears all stage registers, the output register and the valid pipeline to 0.
  - After reset, _QxDO=0 and OutValidxSO=0.
  - Reset takes priority over EnxSI.
  - Reset mid-operation discards in-flight items; no partial outputs emerge.
- Correctness invariant: XOR of Q shares = (XOR X) * (XOR Y), independent of Z.
- Randomness contract: Z must be fresh for each valid input. The block does not check this.
- Illegal parameters (POLY bit N clear, SHARES<2) stop elaboration via a generate-time error.

Optional Feature:
- Macro DOM_UNMASKED_CHECK_EN.
- Defined:
  - Adds output port UnmaskedQxDO (N bits) = XOR of all _QxDO shares.
  - Adds a simulation assertion: when OutValidxSO=1, UnmaskedQxDO equals the reference product of the delayed unmasked inputs.
  - Debug/verification only; never defined in masked production builds.
- Undefined: port and checker are absent; no additional logic.

Decomposition:
- Package dom_gf_pkg:
  - gf_mul(a, b, n, poly) function;
  - pair_index(i, j, shares) function;
  - constant localparam formula for randomness width N*S*(S-1)/2.
- One natural sub-module, dom_gf2n_term_reg: one N-bit registered product term, with optional Z XOR, enable and synchronous reset. Instantiated SHARES^2 times.

Test Plan:
- N=2, POLY=7, SHARES=3, OUT_REG=0, Z=0, other shares 0; sweep all 16 (X0,Y0) with InValid=1 → one cycle later Q0 equals the product (2*2=3, 3*3=2), Q1=Q2=0, OutValid=1.
- N=4, POLY=0x13, SHARES=2, OUT_REG=1, random shares with unmasked X=0x3, Y=0x7, random Z → after 2 cycles XOR of Q = 0x9; with X=0x8, Y=0x2 → 0x3.
- Same vector repeated with different Z values → individual shares differ, XOR of Q is identical every time.
- Stall: assert EnxSI=0 for 3 cycles mid-stream while toggling inputs → _QxDO and OutValidxSO frozen; after release the pipeline resumes with no item lost or duplicated.
- Reset mid-stream: RstxRI=1 for 1 cycle with 2 items in flight (OUT_REG=1) → next cycle _QxDO=0 and OutValidxSO=0; no stale valid appears afterwards.
- InValid pattern 1,0,1,1,0 at N=4, SHARES=4 → OutValid reproduces the pattern delayed by exactly LAT, and all valid results are correct.
